adder_stim_ctrl: RTL

Synthesizable self-checking stimulus initiator for the 8-bit adder's add_if operand/result path: it is the driver end of the interface the adder responds on. It generates LFSR operand pairs, issues one request at a time with a valid/ready handshake, and checks each response against an internally computed sum/carry. It reports pass/fail, an error count and the first failing operands, and serves as on-chip BIST and as a bench-free regression driver.

---
 rtl/adder_stim_pkg.sv | 19 +
 rtl/adder_stim_lfsr.sv | 37 +++
 rtl/adder_stim_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/adder_stim_pkg.sv
// Shared types and helpers for the adder stimulus initiator.
// The LFSR step function is reusable by other BIST blocks.
package adder_stim_pkg;

    localparam int DATA_W = 8;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/adder_stim_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous load and enable.
// Load takes priority over enable.
module adder_stim_lfsr
    import adder_stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/adder_stim_ctrl.sv
// Self-checking stimulus initiator for the 8-bit adder request/response path.
// Issues LFSR operand pairs one at a time and scores each response.
module adder_stim_ctrl
    import adder_stim_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              req_valid,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_sum,
    input  logic              rsp_carry,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [15:0]       vec_count,
    output logic              timeout_seen,
    output logic [DATA_W-1:0] first_fail_a,
    output logic [DATA_W-1:0] first_fail_b
);

    localparam logic [15:0] NV      = 16'(NUM_VECTORS);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [DATA_W:0]   exp_q, exp_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       err_q, err_d;
    logic [15:0]       vec_q, vec_d;
    logic              to_q, to_d;
    logic [DATA_W-1:0] ffa_q, ffa_d;
    logic [DATA_W-1:0] ffb_q, ffb_d;

    logic        lfsr_load;
    logic        lfsr_en;
    logic [15:0] lfsr_val;
    logic        fail;
    logic        wait_exit;

    adder_stim_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (lfsr_load),
        .en   (lfsr_en),
        .value(lfsr_val)
    );

    assign busy      = (state_q == ISSUE) || (state_q == WAIT);
    assign done      = (state_q == DONE);
    assign req_valid = (state_q == ISSUE);
    // Operands are quiet outside a run so reset leaves the bus at zero.
    assign op_a      = busy ? lfsr_val[15:8] : '0;
    assign op_b      = busy ? lfsr_val[7:0]  : '0;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        timer_d   = timer_q;
        err_d     = err_q;
        vec_d     = vec_q;
        to_d      = to_q;
        ffa_d     = ffa_q;
        ffb_d     = ffb_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        fail      = 1'b0;
        wait_exit = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = ISSUE;
                    err_d     = '0;
                    vec_d     = '0;
                    to_d      = 1'b0;
                    ffa_d     = '0;
                    ffb_d     = '0;
                    lfsr_load = 1'b1;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    exp_d   = {1'b0, op_a} + {1'b0, op_b};
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + 16'd1;
                if (rsp_valid) begin
                    wait_exit = 1'b1;
                    fail      = ({rsp_carry, rsp_sum} != exp_q);
                end else if (timer_q == TO_LAST) begin
                    wait_exit = 1'b1;
                    fail      = 1'b1;
                    to_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'h0000) begin
                ffa_d = op_a;
                ffb_d = op_b;
            end
        end

        if (wait_exit) begin
            lfsr_en = 1'b1;
            vec_d   = vec_q + 16'd1;
            state_d = (vec_q + 16'd1 == NV) ? DONE : ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            timer_q <= '0;
            err_q   <= '0;
            vec_q   <= '0;
            to_q    <= 1'b0;
            ffa_q   <= '0;
            ffb_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            to_q    <= to_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
        end
    end

    assign pass         = done && (err_q == 16'h0000);
    assign err_count    = err_q;
    assign vec_count    = vec_q;
    assign timeout_seen = to_q;
    assign first_fail_a = ffa_q;
    assign first_fail_b = ffb_q;

endmodule
